matrix_stream_loader: RTL

Upstream feeder for the combinational matrix adder. It accepts matrix elements one at a time over a valid/ready stream and assembles two packed 2x2 matrices, operand A then operand B. It presents both matrices as stable 16-bit words with a valid/ready handshake. The adder output is valid whenever `out_valid` is high.

---
 rtl/matrix_stream_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/matrix_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_stream_loader
// Description : Collects matrix elements from a valid/ready element stream
//               and assembles two packed 2x2 matrices (operand A, then B).
//               Elements are gathered in shadow registers. They are copied to
//               the outputs only when a correctly framed 8-element frame
//               completes. The outputs are held with out_valid until the
//               consumer takes them.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - element stream handshake
//               in_data, in_last  - element value, end-of-frame marker
//               out_valid/out_ready - frame handshake toward the adder
//               mat_a, mat_b      - packed operands, element k at [k*W +: W]
//               frame_err         - one-cycle pulse per framing error
//               frame_cnt         - delivered frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_stream_loader #(
    parameter int ELEM_W = 4,
    parameter int N_ELEM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ELEM_W-1:0]        in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEM_W*N_ELEM-1:0] mat_a,
    output logic [ELEM_W*N_ELEM-1:0] mat_b,
    output logic                     frame_err,
    output logic [7:0]               frame_cnt
);

    localparam int MAT_W = ELEM_W * N_ELEM;
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_ELEM - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [MAT_W-1:0]   r_shadow_a;
    logic [MAT_W-1:0]   r_shadow_b;
    logic [MAT_W-1:0]   r_mat_a;
    logic [MAT_W-1:0]   r_mat_b;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_frame_err;
    logic [7:0]         r_frame_cnt;

    logic               w_accept;
    logic               w_idx_last;
    logic [MAT_W-1:0]   w_shadow_b_next;

    assign w_accept   = in_valid & r_in_ready;
    assign w_idx_last = (r_idx == c_IDX_LAST);

    // B shadow including the element arriving this cycle, so the final
    // element can be committed to mat_b on the same edge it is accepted.
    always_comb begin
        w_shadow_b_next = r_shadow_b;
        w_shadow_b_next[r_idx*ELEM_W +: ELEM_W] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= LOAD_A;
            r_idx       <= '0;
            r_shadow_a  <= '0;
            r_shadow_b  <= '0;
            r_mat_a     <= '0;
            r_mat_b     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                LOAD_A: begin
                    if (w_accept) begin
                        if (in_last) begin
                            // Only the 8th element may carry in_last.
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                        end else begin
                            r_shadow_a[r_idx*ELEM_W +: ELEM_W] <= in_data;
                            if (w_idx_last) begin
                                r_idx   <= '0;
                                r_state <= LOAD_B;
                            end else begin
                                r_idx <= r_idx + c_IDX_ONE;
                            end
                        end
                    end
                end
                LOAD_B: begin
                    if (w_accept) begin
                        if (w_idx_last && in_last) begin
                            r_shadow_b  <= w_shadow_b_next;
                            r_mat_a     <= r_shadow_a;
                            r_mat_b     <= w_shadow_b_next;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_idx       <= '0;
                            r_state     <= HOLD;
                        end else if (w_idx_last || in_last) begin
                            // Missing last on the 8th, or early last.
                            r_frame_err <= 1'b1;
                            r_idx       <= '0;
                            r_state     <= LOAD_A;
                        end else begin
                            r_shadow_b[r_idx*ELEM_W +: ELEM_W] <= in_data;
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= LOAD_A;
                    end
                end
                default: begin
                    r_state    <= LOAD_A;
                    r_idx      <= '0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Ready is also shown during reset; nothing is accepted in that cycle.
    assign in_ready  = r_in_ready | rst;
    assign out_valid = r_out_valid;
    assign mat_a     = r_mat_a;
    assign mat_b     = r_mat_b;
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
